// File: rtl/gf2m_mul_digit8_seq.sv
// Digit-serial GF(2^16) multiplier, f(x) = x^16 + x^5 + x^3 + x^2 + 1, 8-bit digits of B MSB first.
// Optional multiply-accumulate (extra c_in operand) enabled by defining GF_MUL_MAC_EN.
module gf2m_mul_digit8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
`ifdef GF_MUL_MAC_EN
  input  logic [15:0] c_in,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q_out
);

  localparam int unsigned M  = 16;
  localparam int unsigned D  = 8;
  localparam int unsigned PW = M + D;
  localparam logic [M-1:0] POLY_LOW = 16'h002D;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  // Fold every coefficient of degree >= M back using x^16 = x^5 + x^3 + x^2 + 1.
  function automatic logic [M-1:0] reduce(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = p;
    for (int i = PW - 1; i >= int'(M); i--) begin
      if (r[i]) r = r ^ (PW'(POLY_LOW) << (i - int'(M))) ^ (PW'(1) << i);
    end
    return r[M-1:0];
  endfunction

  // Carry-less 16x8 product.
  function automatic logic [PW-1:0] clmul(input logic [M-1:0] a, input logic [D-1:0] d);
    logic [PW-1:0] p;
    p = '0;
    for (int j = 0; j < int'(D); j++) begin
      if (d[j]) p = p ^ (PW'(a) << j);
    end
    return p;
  endfunction

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [M-1:0]   a_q, a_d;
  logic [M-1:0]   b_q, b_d;
  logic [M-1:0]   acc_q, acc_d;
  logic [M-1:0]   q_q, q_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [D-1:0]   digit;
  logic [M-1:0]   acc_step;
`ifdef GF_MUL_MAC_EN
  logic [M-1:0]   c_q, c_d;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q_out     = q_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; cnt 0/1 are digit cycles, cnt 2 loads the output register
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid && in_ready_q) state_d = MUL;
      MUL:     if (cnt_q == 2'd2) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Horner step: acc * x^8 mod f, plus A * digit mod f
  always_comb begin
    digit    = (cnt_q == 2'd0) ? b_q[15:8] : b_q[7:0];
    acc_step = reduce({acc_q, D'(0)}) ^ reduce(clmul(a_q, digit));
`ifdef GF_MUL_MAC_EN
    if (cnt_q == 2'd1) acc_step = acc_step ^ c_q;
`endif
  end

  // Datapath and output next values
  always_comb begin
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    q_d         = q_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef GF_MUL_MAC_EN
    c_d         = c_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a_in;
          b_d        = b_in;
`ifdef GF_MUL_MAC_EN
          c_d        = c_in;
`endif
          acc_d      = '0;
          cnt_d      = 2'd0;
          in_ready_d = 1'b0;
        end
      end
      MUL: begin
        if (cnt_q != 2'd2) begin
          acc_d = acc_step;
          cnt_d = cnt_q + 2'd1;
        end else begin
          q_d         = acc_q;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef GF_MUL_MAC_EN
      c_q         <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef GF_MUL_MAC_EN
      c_q         <= c_d;
`endif
    end
  end

endmodule

// File: tb/tb_gf2m_mul_digit8_seq.sv
// Randomized self-checking bench for gf2m_mul_digit8_seq against a bit-serial GF(2^16) model.
module tb_gf2m_mul_digit8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
`ifdef GF_MUL_MAC_EN
  logic [15:0] c_in;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q_out;

  int n_checks = 0;
  int n_errors = 0;

  gf2m_mul_digit8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
`ifdef GF_MUL_MAC_EN
    .c_in      (c_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_out     (q_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Shift-and-add multiply, one bit of b per step, reducing x^16 as it appears.
  function automatic logic [15:0] gf_mul_ref(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      r = r << 1;
      if (r[16]) r = r ^ 17'h1002D;
      if (b[i]) r = r ^ {1'b0, a};
    end
    return r[15:0];
  endfunction

  function automatic logic [15:0] mac_term(input logic [15:0] c);
`ifdef GF_MUL_MAC_EN
    return c;
`else
    return 16'h0000 & c;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check("in_ready_wait", 16'(in_ready), 16'd1);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
`ifdef GF_MUL_MAC_EN
    c_in     = c;
`else
    if (c != 16'h0) $display("note: c operand ignored without MAC");
`endif
    tick();
    in_valid = 1'b0;
    a_in     = 16'($urandom);
    b_in     = 16'($urandom);
`ifdef GF_MUL_MAC_EN
    c_in     = 16'($urandom);
`endif
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("retire_out_valid", 16'(out_valid), 16'd0);
    check("retire_in_ready", 16'(in_ready), 16'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] exp, input bit chk_lat);
    int k;
    send(a, b, c);
    wait_valid(k);
    if (chk_lat) check({tag, "_latency"}, 16'(k), 16'd3);
    else if (k >= 20) check({tag, "_timeout"}, 16'(out_valid), 16'd1);
    check(tag, q_out, exp);
    retire();
  endtask

  initial begin
    logic [15:0] a, b, c, held;
    int k;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0;
`ifdef GF_MUL_MAC_EN
    c_in = '0;
`endif
    #12;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_q_out", q_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_in_ready", 16'(in_ready), 16'd1);
    check("idle_out_valid", 16'(out_valid), 16'd0);
    check("idle_q_out", q_out, 16'h0000);

    run_op("identity",  16'h0001, 16'h1234, 16'h0, 16'h1234, 1'b1);
    run_op("x8_x8",     16'h0100, 16'h0100, 16'h0, 16'h002D, 1'b1);
    run_op("x15_x1",    16'h8000, 16'h0002, 16'h0, 16'h002D, 1'b1);
    run_op("x15_x15",   16'h8000, 16'h8000, 16'h0, 16'h411F, 1'b1);
    run_op("zero_ones", 16'h0000, 16'hFFFF, 16'h0, 16'h0000, 1'b1);

    // Backpressure: hold result, offer a competing operand that must be ignored
    a = 16'h1357; b = 16'hBEEF;
    send(a, b, 16'h0);
    wait_valid(k);
    check("bp_latency", 16'(k), 16'd3);
    held = q_out;
    check("bp_result", held, gf_mul_ref(a, b));
    in_valid = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", 16'(out_valid), 16'd1);
      check("bp_in_ready", 16'(in_ready), 16'd0);
      check("bp_q_stable", q_out, held);
    end
    in_valid = 1'b0;
    retire();
    tick();
    check("bp_no_accept", 16'(in_ready), 16'd1);
    run_op("bp_next", 16'h0003, 16'h0005, 16'h0, 16'h000F, 1'b1);

    // Reset during the first MUL cycle
    send(16'h4321, 16'h8765, 16'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 16'(in_ready), 16'd1);
    check("midrst_out_valid", 16'(out_valid), 16'd0);
    check("midrst_q_out", q_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst_quiet", 16'(out_valid), 16'd0);
    run_op("after_rst", 16'h0100, 16'h0100, 16'h0, 16'h002D, 1'b1);

`ifdef GF_MUL_MAC_EN
    run_op("mac_cancel", 16'h0100, 16'h0100, 16'h002D, 16'h0000, 1'b1);
`endif

    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 16'($urandom);
      if (n == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
      run_op("random", a, b, c, gf_mul_ref(a, b) ^ mac_term(c), (n % 50) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
